adc_sample_sequencer: RTL and testbench

- Control and capture stage directly downstream of the 8-bit SAR converter core.
- Issues periodic active-low conversion-start pulses to the core and detects end of conversion from the core's done flag.
- Captures the core's 8-bit result, averages 2^AVG_LOG2 conversions, and presents the averaged sample on a valid/ready interface to the rest of the design.

---
 rtl/adc_sample_sequencer.sv | 144 ++++++++++++++
 tb/tb_adc_sample_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_sequencer.sv
// Periodic start/capture sequencer for an 8-bit SAR core with 2^AVG_LOG2 averaging.
// Result appears 1 clock after the final capture, is held until accepted and is overwritten (overrun) if not taken.
module adc_sample_sequencer #(
  parameter int SAMPLE_PERIOD = 64,
  parameter int AVG_LOG2      = 2,
  parameter int TIMEOUT       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       convStart,
  input  logic       convStop,
  input  logic [7:0] adcData,
  output logic [7:0] sampleData,
  output logic       sampleValid,
  input  logic       sampleReady,
  output logic       overrun,
  output logic       timeout,
  input  logic       clearFlags
);
  localparam int ACC_W = 8 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] NUM_AVG     = CNT_W'(1 << AVG_LOG2);
  localparam logic [15:0]      PERIOD_LAST = 16'(SAMPLE_PERIOD - 1);
  localparam logic [7:0]       TO_LAST     = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, START, WAIT_LOW, WAIT_HIGH, PERIOD} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [15:0]      per_cnt;
  logic [7:0]       to_cnt;
  logic             start_cnt;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] smp_cnt;
  logic             waiting;
  logic             capture;
  logic             to_expire;
  logic             per_done;
  logic             result_load;

  assign waiting     = (state == WAIT_LOW) || (state == WAIT_HIGH);
  assign capture     = (state == WAIT_HIGH) && convStop;
  // A done seen on the deadline edge still counts as a good conversion.
  assign to_expire   = waiting && !capture && (to_cnt == TO_LAST);
  assign per_done    = per_cnt >= PERIOD_LAST;
  assign result_load = smp_cnt == NUM_AVG;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable) state_nxt = START;
      end
      START: begin
        if (start_cnt) state_nxt = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (to_expire) begin
          state_nxt = PERIOD;
        end else if (!convStop) begin
          state_nxt = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (capture || to_expire) state_nxt = PERIOD;
      end
      PERIOD: begin
        if (per_done) state_nxt = enable ? START : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    convStart = 1'b1;
    if (state == START) convStart = 1'b0;
  end

  // Period counter restarts on every START entry so starts sit on a fixed grid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_cnt <= 1'b0;
      per_cnt   <= 16'd0;
      to_cnt    <= 8'd0;
    end else begin
      start_cnt <= (state == START) ? ~start_cnt : 1'b0;
      if ((state != START) && (state_nxt == START)) begin
        per_cnt <= 16'd0;
      end else if (per_cnt != 16'hFFFF) begin
        per_cnt <= per_cnt + 16'd1;
      end
      to_cnt <= waiting ? to_cnt + 8'd1 : 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      smp_cnt <= '0;
    end else if (result_load || (state == IDLE)) begin
      acc     <= '0;
      smp_cnt <= '0;
    end else if (capture) begin
      acc     <= acc + ACC_W'(adcData);
      smp_cnt <= smp_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sampleData  <= 8'd0;
      sampleValid <= 1'b0;
      overrun     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      if (result_load) begin
        sampleData  <= acc[ACC_W-1 -: 8];
        sampleValid <= 1'b1;
      end else if (sampleValid && sampleReady) begin
        sampleValid <= 1'b0;
      end
      if (result_load && sampleValid && !sampleReady) begin
        overrun <= 1'b1;
      end else if (clearFlags) begin
        overrun <= 1'b0;
      end
      if (to_expire) begin
        timeout <= 1'b1;
      end else if (clearFlags) begin
        timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Directed bench for adc_sample_sequencer with a behavioural SAR core model.
module tb_adc_sample_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       convStart;
  logic       convStop;
  logic [7:0] adcData;
  logic [7:0] sampleData;
  logic       sampleValid;
  logic       sampleReady;
  logic       overrun;
  logic       timeout;
  logic       clearFlags;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic       core_stuck = 1'b0;
  logic [7:0] core_q[$];
  int         core_done = 0;
  int         busy = 0;

  int         start_q[$];
  int         low_q[$];
  logic [7:0] smp_q[$];
  int         low_run = 0;
  logic       prev_start = 1'b1;

  adc_sample_sequencer #(.SAMPLE_PERIOD(64), .AVG_LOG2(2), .TIMEOUT(32)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .convStart(convStart),
    .convStop(convStop), .adcData(adcData), .sampleData(sampleData),
    .sampleValid(sampleValid), .sampleReady(sampleReady), .overrun(overrun),
    .timeout(timeout), .clearFlags(clearFlags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SAR core: drops done on a start, returns the next queued value 6 clocks later.
  initial begin
    convStop = 1'b1;
    adcData  = 8'h00;
    forever begin
      @(negedge clk);
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          adcData = (core_q.size() > 0) ? core_q.pop_front() : 8'h00;
          convStop = 1'b1;
          core_done++;
        end
      end else if (!core_stuck && !convStart && convStop) begin
        convStop = 1'b0;
        busy = 6;
      end
    end
  end

  always @(negedge clk) begin
    if (!convStart) begin
      if (prev_start) start_q.push_back(cyc);
      low_run++;
    end else if (!prev_start) begin
      low_q.push_back(low_run);
      low_run = 0;
    end
    prev_start = convStart;
    if (sampleValid && sampleReady) smp_q.push_back(sampleData);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic wait_starts(input int n, input int budget);
    int k = 0;
    while (start_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (start_q.size() < n) begin
      errors++;
      $display("FAIL start_wait: starts seen %0d, required %0d", start_q.size(), n);
    end
  endtask

  task automatic wait_samples(input int n, input int budget);
    int k = 0;
    while (smp_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
  endtask

  task automatic idle_out();
    @(posedge clk); #1 enable = 1'b0;
    repeat (100) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; sampleReady = 1'b0; clearFlags = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (convStart !== 1'b1) begin
      errors++; $display("FAIL reset_convstart_in_reset: got %b, want 1", convStart);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    start_q.delete(); smp_q.delete();
    repeat (200) @(posedge clk);
    @(negedge clk);
    checks++;
    if (start_q.size() != 0) begin
      errors++; $display("FAIL reset_no_start: got %0d starts, want 0", start_q.size());
    end
    checks++;
    if (sampleValid !== 1'b0 || sampleData !== 8'h00) begin
      errors++; $display("FAIL reset_sample: got valid %b data %h, want 0 00", sampleValid, sampleData);
    end
    checks++;
    if (overrun !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got ovr %b to %b, want 0 0", overrun, timeout);
    end
  endtask

  task automatic test_average();
    core_q = '{8'h10, 8'h20, 8'h30, 8'h41};
    start_q.delete(); low_q.delete(); smp_q.delete();
    @(posedge clk); #1 sampleReady = 1'b1; enable = 1'b1;
    wait_starts(4, 400);
    wait_samples(1, 100);
    checks++;
    if (smp_q.size() != 1 || smp_q[0] !== 8'h28) begin
      errors++; $display("FAIL avg_sample: got %0d samples first %h, want 1 sample 28", smp_q.size(), smp_q[0]);
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (start_q.size() <= i || start_q[i] - start_q[i-1] != 64) begin
        errors++; $display("FAIL avg_spacing[%0d]: got %0d clocks, want 64", i, start_q[i] - start_q[i-1]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (low_q.size() <= i || low_q[i] != 2) begin
        errors++; $display("FAIL avg_low_width[%0d]: got %0d clocks, want 2", i, low_q[i]);
      end
    end
    idle_out();
    checks++;
    if (smp_q.size() != 1 || start_q.size() != 4 || overrun !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL avg_after: got %0d samples %0d starts ovr %b to %b, want 1 4 0 0",
                         smp_q.size(), start_q.size(), overrun, timeout);
    end
  endtask

  task automatic test_timeout();
    int e0;
    int k;
    core_q = '{8'h04, 8'h08, 8'h0C, 8'h10};
    start_q.delete(); smp_q.delete();
    core_stuck = 1'b1;
    @(posedge clk); #1 enable = 1'b1;
    wait_starts(1, 20);
    e0 = start_q[0];
    k = 0;
    while (cyc < e0 + 33 && k < 100) begin @(negedge clk); k++; end
    checks++;
    if (timeout !== 1'b0) begin
      errors++; $display("FAIL to_early: got timeout %b at start+33, want 0", timeout);
    end
    @(negedge clk);
    checks++;
    if (timeout !== 1'b1) begin
      errors++; $display("FAIL to_set: got timeout %b at start+34, want 1", timeout);
    end
    core_stuck = 1'b0;
    @(posedge clk); #1 clearFlags = 1'b1;
    @(posedge clk); #1 clearFlags = 1'b0;
    @(negedge clk);
    checks++;
    if (timeout !== 1'b0) begin
      errors++; $display("FAIL to_clear: got timeout %b, want 0", timeout);
    end
    wait_starts(5, 400);
    wait_samples(1, 100);
    checks++;
    if (start_q.size() < 2 || start_q[1] - start_q[0] != 64) begin
      errors++; $display("FAIL to_grid: got %0d clocks, want 64", start_q[1] - start_q[0]);
    end
    checks++;
    if (smp_q.size() != 1 || smp_q[0] !== 8'h0A) begin
      errors++; $display("FAIL to_sample: got %0d samples first %h, want 1 sample 0a", smp_q.size(), smp_q[0]);
    end
    idle_out();
  endtask

  task automatic test_overrun();
    int k;
    core_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    @(posedge clk); #1 sampleReady = 1'b0; enable = 1'b1;
    k = 0;
    while (sampleValid !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    checks++;
    if (sampleValid !== 1'b1 || sampleData !== 8'hFF || overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_first: got valid %b data %h ovr %b, want 1 ff 0", sampleValid, sampleData, overrun);
    end
    k = 0;
    while (overrun !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    checks++;
    if (sampleValid !== 1'b1 || sampleData !== 8'h00 || overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_second: got valid %b data %h ovr %b, want 1 00 1", sampleValid, sampleData, overrun);
    end
    idle_out();
    @(posedge clk); #1 sampleReady = 1'b1;
    @(posedge clk); #1 sampleReady = 1'b0;
    @(negedge clk);
    checks++;
    if (sampleValid !== 1'b0 || overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_accept: got valid %b ovr %b, want 0 1", sampleValid, overrun);
    end
    @(posedge clk); #1 clearFlags = 1'b1;
    @(posedge clk); #1 clearFlags = 1'b0;
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_clear: got ovr %b, want 0", overrun);
    end
  endtask

  task automatic test_enable_drop();
    core_q = '{8'h01, 8'h02, 8'h03};
    start_q.delete(); smp_q.delete();
    @(posedge clk); #1 sampleReady = 1'b1; enable = 1'b1;
    wait_starts(3, 300);
    @(posedge clk); #1 enable = 1'b0;
    repeat (150) @(posedge clk);
    @(negedge clk);
    checks++;
    if (start_q.size() != 3 || smp_q.size() != 0 || convStart !== 1'b1) begin
      errors++; $display("FAIL drop_idle: got %0d starts %0d samples convStart %b, want 3 0 1",
                         start_q.size(), smp_q.size(), convStart);
    end
    checks++;
    if (core_q.size() != 0) begin
      errors++; $display("FAIL drop_finish: got %0d conversions unfinished, want 0", core_q.size());
    end
    core_q = '{8'h80, 8'h80, 8'h80, 8'h80};
    @(posedge clk); #1 enable = 1'b1;
    wait_starts(7, 400);
    wait_samples(1, 100);
    checks++;
    if (smp_q.size() != 1 || smp_q[0] !== 8'h80) begin
      errors++; $display("FAIL drop_resume: got %0d samples first %h, want 1 sample 80", smp_q.size(), smp_q[0]);
    end
    idle_out();
  endtask

  task automatic test_back_to_back();
    int base;
    int k;
    core_q = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22};
    base = core_done;
    @(posedge clk); #1 sampleReady = 1'b0; enable = 1'b1;
    k = 0;
    while (sampleValid !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    checks++;
    if (sampleValid !== 1'b1 || sampleData !== 8'h11) begin
      errors++; $display("FAIL b2b_first: got valid %b data %h, want 1 11", sampleValid, sampleData);
    end
    k = 0;
    while (core_done < base + 8 && k < 400) begin @(posedge clk); k++; end
    // This edge captures the last conversion; the result loads on the next one.
    #1 sampleReady = 1'b1;
    @(posedge clk); #1 sampleReady = 1'b0;
    @(negedge clk);
    checks++;
    if (sampleValid !== 1'b1 || sampleData !== 8'h22 || overrun !== 1'b0) begin
      errors++; $display("FAIL b2b_new_wins: got valid %b data %h ovr %b, want 1 22 0", sampleValid, sampleData, overrun);
    end
  endtask

  task automatic test_reset_mid();
    start_q.delete(); smp_q.delete();
    wait_starts(1, 200);
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (sampleValid !== 1'b1 || convStop !== 1'b0) begin
      errors++; $display("FAIL rstmid_pre: got valid %b convStop %b, want 1 0", sampleValid, convStop);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (convStart !== 1'b1 || sampleValid !== 1'b0 || sampleData !== 8'h00) begin
      errors++; $display("FAIL rstmid_outputs: got start %b valid %b data %h, want 1 0 00", convStart, sampleValid, sampleData);
    end
    checks++;
    if (overrun !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL rstmid_flags: got ovr %b to %b, want 0 0", overrun, timeout);
    end
    enable = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b1;
    start_q.delete(); smp_q.delete();
    core_q = '{8'h40, 8'h40, 8'h40, 8'h40};
    repeat (100) @(posedge clk);
    checks++;
    if (start_q.size() != 0) begin
      errors++; $display("FAIL rstmid_idle: got %0d starts, want 0", start_q.size());
    end
    #1 sampleReady = 1'b1; enable = 1'b1;
    wait_starts(4, 400);
    wait_samples(1, 100);
    checks++;
    if (smp_q.size() != 1 || smp_q[0] !== 8'h40) begin
      errors++; $display("FAIL rstmid_fresh: got %0d samples first %h, want 1 sample 40", smp_q.size(), smp_q[0]);
    end
    idle_out();
  endtask

  initial begin
    test_reset();
    test_average();
    test_timeout();
    test_overrun();
    test_enable_drop();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
